// File: rtl/logic_op_scheduler.sv
// logic_op_scheduler
// Round-robin front end that shares one combinational 8-bit logic unit
// (XOR/AND/OR/NOT) among NUM_REQ requesters.
//
// Ports:
//   Clk, Rst_n        clock, synchronous active-low reset
//   Req               per-requester request level, held until granted
//   Op_in/A_in/B_in   per-requester opcode and operands (packed slices)
//   Grant             one-hot pulse: that requester's operands were latched
//   Unit_In1/In2/Sel  registered operands/opcode toward the shared unit
//   Unit_Out          combinational result from the shared unit
//   Result/_id/_valid captured result, owner and valid flag
//   Result_ack        consumer accepts Result when high with Result_valid
//   Busy              high while an operation is in flight (ISSUE/DONE)
//   Dbg_state         current FSM state (00 IDLE, 01 ISSUE, 10 DONE)
//
// Handshake: a result transfers on a rising edge where Result_valid and
// Result_ack are both high; Result/Result_id hold steady until then.
module logic_op_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [2*NUM_REQ-1:0]     Op_in,
    input  logic [WIDTH*NUM_REQ-1:0] A_in,
    input  logic [WIDTH*NUM_REQ-1:0] B_in,
    output logic [NUM_REQ-1:0]       Grant,
    output logic [WIDTH-1:0]         Unit_In1,
    output logic [WIDTH-1:0]         Unit_In2,
    output logic [1:0]               Unit_Sel,
    input  logic [WIDTH-1:0]         Unit_Out,
    output logic [WIDTH-1:0]         Result,
    output logic [IDW-1:0]           Result_id,
    output logic                     Result_valid,
    input  logic                     Result_ack,
    output logic                     Busy,
    output logic [1:0]               Dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [IDW-1:0]       last;
    logic [IDW-1:0]       cur;
    logic [IDW-1:0]       win;
    logic                 found;
    logic                 any_req;
    logic                 arb_fire;
    logic [WIDTH-1:0]     opnd_a;
    logic [WIDTH-1:0]     opnd_b;
    logic [1:0]           opnd_sel;
    logic [NUM_REQ-1:0]   grant_q;
    logic [WIDTH-1:0]     result_q;
    logic [IDW-1:0]       result_id_q;
    logic                 result_valid_q;

    assign any_req = |Req;

    // Arbitration happens from IDLE, or from DONE on the accepting edge so
    // back-to-back operations need no IDLE bubble.
    assign arb_fire = any_req &&
                      ((state == ST_IDLE) || ((state == ST_DONE) && Result_ack));

    // Round-robin search starting just after the last served requester.
    always_comb begin : arb
        logic [IDW-1:0] idx;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last) + k) % NUM_REQ);
            if (!found && Req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_DONE;
            ST_DONE:  if (Result_ack) state_nxt = any_req ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state          <= ST_IDLE;
            last           <= IDW'(NUM_REQ - 1);
            cur            <= '0;
            opnd_a         <= '0;
            opnd_b         <= '0;
            opnd_sel       <= 2'b00;
            grant_q        <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= '0;
            if (arb_fire) begin
                opnd_a   <= A_in[WIDTH*win +: WIDTH];
                opnd_b   <= B_in[WIDTH*win +: WIDTH];
                opnd_sel <= Op_in[2*win +: 2];
                cur      <= win;
                grant_q  <= NUM_REQ'(1) << win;
            end
            if (state == ST_ISSUE) begin
                result_q       <= Unit_Out;
                result_id_q    <= cur;
                result_valid_q <= 1'b1;
                last           <= cur;
            end else if ((state == ST_DONE) && Result_ack) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    assign Grant        = grant_q;
    assign Unit_In1     = opnd_a;
    assign Unit_In2     = opnd_b;
    assign Unit_Sel     = opnd_sel;
    assign Result       = result_q;
    assign Result_id    = result_id_q;
    assign Result_valid = result_valid_q;
    assign Busy         = (state != ST_IDLE);
    assign Dbg_state    = state;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Bench for logic_op_scheduler: a 4-requester instance with directed
// scenarios and a 2-requester instance with alternating requests. Both
// drive a behavioural model of the shared logic unit.
module tb_logic_op_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-requester instance
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] op_in = '0;
  logic [W*N-1:0] a_in = '0;
  logic [W*N-1:0] b_in = '0;
  logic [N-1:0]   grant;
  logic [W-1:0]   unit_in1, unit_in2, unit_out, result;
  logic [1:0]     unit_sel, result_id, dbg_state;
  logic           result_valid, busy;
  logic           result_ack = 1'b1;

  always_comb begin
    case (unit_sel)
      2'b00:   unit_out = unit_in1 ^ unit_in2;
      2'b01:   unit_out = unit_in1 & unit_in2;
      2'b10:   unit_out = unit_in1 | unit_in2;
      default: unit_out = ~unit_in1;
    endcase
  end

  logic_op_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .Clk(clk), .Rst_n(rst_n), .Req(req), .Op_in(op_in), .A_in(a_in), .B_in(b_in),
    .Grant(grant), .Unit_In1(unit_in1), .Unit_In2(unit_in2), .Unit_Sel(unit_sel),
    .Unit_Out(unit_out), .Result(result), .Result_id(result_id),
    .Result_valid(result_valid), .Result_ack(result_ack), .Busy(busy),
    .Dbg_state(dbg_state)
  );

  // 2-requester instance
  logic [1:0]  req2 = '0;
  logic [3:0]  op2 = '0;
  logic [15:0] a2 = '0;
  logic [15:0] b2 = '0;
  logic [1:0]  grant2, sel2, dbg2;
  logic [7:0]  in1_2, in2_2, out2, result2;
  logic [0:0]  rid2;
  logic        rv2, busy2;
  logic        ack2 = 1'b1;

  always_comb begin
    case (sel2)
      2'b00:   out2 = in1_2 ^ in2_2;
      2'b01:   out2 = in1_2 & in2_2;
      2'b10:   out2 = in1_2 | in2_2;
      default: out2 = ~in1_2;
    endcase
  end

  logic_op_scheduler #(.NUM_REQ(2), .WIDTH(W)) dut2 (
    .Clk(clk), .Rst_n(rst_n), .Req(req2), .Op_in(op2), .A_in(a2), .B_in(b2),
    .Grant(grant2), .Unit_In1(in1_2), .Unit_In2(in2_2), .Unit_Sel(sel2),
    .Unit_Out(out2), .Result(result2), .Result_id(rid2),
    .Result_valid(rv2), .Result_ack(ack2), .Busy(busy2), .Dbg_state(dbg2)
  );

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [21:0] exp_g_q[$];   // {grant, in1, in2, sel}
  logic [9:0]  exp_r_q[$];   // {id, result}
  logic [1:0]  exp2_g_q[$];  // grant
  logic [8:0]  exp2_r_q[$];  // {id, result}
  logic [21:0] eg;
  logic [9:0]  er;
  logic [1:0]  eg2;
  logic [8:0]  er2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (grant != '0) begin
        if (exp_g_q.size() == 0) check("unexpected_grant", 64'(grant), 64'(0));
        else begin
          eg = exp_g_q.pop_front();
          check("grant_issue", {grant, unit_in1, unit_in2, unit_sel}, 64'(eg));
        end
      end
      if (result_valid && result_ack) begin
        if (exp_r_q.size() == 0) check("unexpected_result", {result_id, result}, 64'hdead);
        else begin
          er = exp_r_q.pop_front();
          check("result", {result_id, result}, 64'(er));
        end
      end
      if (grant2 != '0) begin
        if (exp2_g_q.size() == 0) check("n2_unexpected_grant", 64'(grant2), 64'(0));
        else begin
          eg2 = exp2_g_q.pop_front();
          check("n2_grant", 64'(grant2), 64'(eg2));
        end
      end
      if (rv2 && ack2) begin
        if (exp2_r_q.size() == 0) check("n2_unexpected_result", {rid2, result2}, 64'hdead);
        else begin
          er2 = exp2_r_q.pop_front();
          check("n2_result", {rid2, result2}, 64'(er2));
        end
      end
    end
  end

  // driver tasks
  task automatic set_op(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    op_in[2*i +: 2] = op;
    a_in[8*i +: 8]  = a;
    b_in[8*i +: 8]  = b;
  endtask

  task automatic expect_op(input int i, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] res, input bit with_res);
    logic [3:0] g;
    g = 4'b0001 << i;
    exp_g_q.push_back({g, a, b, op});
    if (with_res) exp_r_q.push_back({2'(i), res});
  endtask

  // returns at the negedge of the cycle in which Grant[i] is high
  task automatic wait_grant(input int i);
    bit seen;
    seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (grant[i]) seen = 1;
    end
    if (!seen) check("grant_timeout", 64'(i), 64'hff);
  endtask

  task automatic drop(input int i);
    @(posedge clk);
    #1 req[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int n = 0; n < 30 && !idle; n++) begin
      @(negedge clk);
      if (!busy && !result_valid && !busy2 && !rv2) idle = 1;
    end
    if (!idle) check("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    req = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int prev;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a", {grant, unit_in1, unit_in2, unit_sel}, 64'(0));
    check("rst_b", {result, result_id, result_valid, busy, dbg_state}, 64'(0));
    #1 rst_n = 1'b1;

    // continuous requests from all four, distinct ops
    @(posedge clk);
    #1;
    set_op(0, 2'b00, 8'hF0, 8'h3C);
    set_op(1, 2'b01, 8'hF0, 8'h3C);
    set_op(2, 2'b10, 8'hF0, 8'h3C);
    set_op(3, 2'b11, 8'hF0, 8'h3C);
    expect_op(0, 2'b00, 8'hF0, 8'h3C, 8'hCC, 1);
    expect_op(1, 2'b01, 8'hF0, 8'h3C, 8'h30, 1);
    expect_op(2, 2'b10, 8'hF0, 8'h3C, 8'hFC, 1);
    expect_op(3, 2'b11, 8'hF0, 8'h3C, 8'h0F, 1);
    expect_op(0, 2'b00, 8'hF0, 8'h3C, 8'hCC, 1);
    req = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(g % 4);
      if (g > 0) check("grant_spacing", 64'(cyc - prev), 64'(2));
      prev = cyc;
    end
    @(posedge clk);
    #1 req = '0;
    wait_idle();

    // single op with latency checks
    do_reset();
    @(posedge clk);
    #1;
    set_op(2, 2'b00, 8'hA5, 8'h0F);
    expect_op(2, 2'b00, 8'hA5, 8'h0F, 8'hAA, 1);
    req = 4'b0100;
    @(negedge clk);
    check("lat_no_grant_yet", 64'(grant), 64'(0));
    @(negedge clk);
    check("lat_grant", 64'(grant), 64'(4'b0100));
    check("lat_unit_in", {unit_in1, unit_in2, unit_sel}, {8'hA5, 8'h0F, 2'b00});
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    check("lat_valid", {result_valid, result_id, result}, {1'b1, 2'd2, 8'hAA});
    check("lat_grant_cleared", 64'(grant), 64'(0));
    @(negedge clk);
    check("valid_one_cycle", 64'(result_valid), 64'(0));
    wait_idle();

    // back-pressure
    do_reset();
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    set_op(0, 2'b01, 8'h5A, 8'hFF);
    set_op(1, 2'b00, 8'h12, 8'h34);
    expect_op(0, 2'b01, 8'h5A, 8'hFF, 8'h5A, 1);
    expect_op(1, 2'b00, 8'h12, 8'h34, 8'h26, 1);
    req = 4'b0011;
    wait_grant(0);
    drop(0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_hold", {grant, result_valid, result_id, result}, {4'b0000, 1'b1, 2'd0, 8'h5A});
    end
    @(posedge clk);
    #1 result_ack = 1'b1;
    @(negedge clk);
    check("bp_no_grant_before_ack_edge", 64'(grant), 64'(0));
    @(negedge clk);
    check("bp_grant_at_ack_edge", 64'(grant), 64'(4'b0010));
    drop(1);
    wait_idle();

    // fairness wrap
    do_reset();
    @(posedge clk);
    #1;
    set_op(3, 2'b10, 8'h81, 8'h18);
    expect_op(3, 2'b10, 8'h81, 8'h18, 8'h99, 1);
    req = 4'b1000;
    wait_grant(3);
    drop(3);
    wait_idle();
    @(posedge clk);
    #1;
    set_op(0, 2'b11, 8'h3C, 8'h77);
    expect_op(0, 2'b11, 8'h3C, 8'h77, 8'hC3, 1);
    expect_op(3, 2'b10, 8'h81, 8'h18, 8'h99, 1);
    req = 4'b1001;
    wait_grant(0);
    drop(0);
    wait_grant(3);
    drop(3);
    wait_idle();

    // reset during ISSUE
    do_reset();
    @(posedge clk);
    #1;
    set_op(2, 2'b01, 8'hEE, 8'h0F);
    expect_op(2, 2'b01, 8'hEE, 8'h0F, 8'h0E, 0);
    req = 4'b0100;
    wait_grant(2);
    #1 rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    check("midrst_a", {grant, unit_in1, unit_in2, unit_sel}, 64'(0));
    check("midrst_b", {result, result_id, result_valid, busy, dbg_state}, 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_op(0, 2'b00, 8'hF0, 8'h3C);
    set_op(1, 2'b01, 8'hF0, 8'h3C);
    set_op(2, 2'b10, 8'hF0, 8'h3C);
    set_op(3, 2'b11, 8'hF0, 8'h3C);
    expect_op(0, 2'b00, 8'hF0, 8'h3C, 8'hCC, 1);
    expect_op(1, 2'b01, 8'hF0, 8'h3C, 8'h30, 1);
    expect_op(2, 2'b10, 8'hF0, 8'h3C, 8'hFC, 1);
    expect_op(3, 2'b11, 8'hF0, 8'h3C, 8'h0F, 1);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(i);
      drop(i);
    end
    wait_idle();

    // two-requester build: alternating grants, 1-bit id
    @(posedge clk);
    #1;
    op2 = {2'b01, 2'b00};
    a2  = {8'hC3, 8'h55};
    b2  = {8'h0F, 8'hFF};
    for (int k = 0; k < 4; k++) begin
      exp2_g_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
      exp2_r_q.push_back((k % 2 == 0) ? {1'b0, 8'hAA} : {1'b1, 8'h03});
    end
    req2 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 30 && !seen; n++) begin
        @(negedge clk);
        if (grant2 != '0) seen = 1;
      end
      if (!seen) check("n2_grant_timeout", 64'(k), 64'hff);
    end
    @(posedge clk);
    #1 req2 = '0;
    wait_idle();

    // every expectation consumed
    check("grant_queue_drained", 64'(exp_g_q.size()), 64'(0));
    check("result_queue_drained", 64'(exp_r_q.size()), 64'(0));
    check("n2_grant_queue_drained", 64'(exp2_g_q.size()), 64'(0));
    check("n2_result_queue_drained", 64'(exp2_r_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_op_scheduler.md
# logic_op_scheduler

Round-robin scheduler that shares the single 8-bit bitwise logic unit (XOR/AND/OR/NOT) of the digital signal processor among several requesters. It arbitrates among pending requests and registers the winner's operands and opcode onto the shared unit's inputs. It then captures the unit's combinational output and returns it with the requester ID over a valid/acknowledge handshake. Requesters are the DSP datapath stages (filter, scrambler, mask logic) that previously needed private gate instances.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8); requester ID width IDW = clog2(NUM_REQ)
- WIDTH, 8, operand/result width

Ports:
- Clk  input  1  single clock, all logic on rising edge
- Rst_n  input  1  synchronous active-low reset, sampled on rising edge of Clk
- Req  input  NUM_REQ  request per requester; level, held until granted
- Op_in  input  2*NUM_REQ  opcode per requester, slice i = Op_in[2i+1:2i]; 00 XOR, 01 AND, 10 OR, 11 NOT In1
- A_in  input  WIDTH*NUM_REQ  operand 1 per requester, slice i = A_in[WIDTH*i +: WIDTH]
- B_in  input  WIDTH*NUM_REQ  operand 2 per requester, same slicing
- Grant  output  NUM_REQ  one-hot, one-cycle pulse: operands of that requester were latched
- Unit_In1  output  WIDTH  to shared logic unit In1
- Unit_In2  output  WIDTH  to shared logic unit In2
- Unit_Sel  output  2  opcode to shared logic unit
- Unit_Out  input  WIDTH  combinational result from shared logic unit
- Result  output  WIDTH  captured result
- Result_id  output  IDW  requester that owns Result
- Result_valid  output  1  Result/Result_id valid
- Result_ack  input  1  consumer accepts result when high with Result_valid
- Busy  output  1  high in ISSUE or DONE

## Operation
- State machine: IDLE, ISSUE, DONE; reset → IDLE.
- Arbitration: round-robin. Pointer Last (IDW bits) resets to NUM_REQ-1, so requester 0 wins first. Search order is Last+1, Last+2, … modulo NUM_REQ. The first asserted Req wins.
- IDLE:
  - If any Req is high, latch A, B and Op of the winner into operand registers and the winner index into Cur.
  - In the same edge, pulse Grant[winner] and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Unit_In1, Unit_In2 and Unit_Sel are driven directly from the operand registers. They are stable for this whole cycle.
  - At the edge: Result ← Unit_Out, Result_id ← Cur, Result_valid ← 1, Last ← Cur, go to DONE.
  - Req is ignored in ISSUE.
- DONE: Result and Result_valid hold until Result_ack = 1. At the acknowledging edge, Result_valid ← 0, and:
  - if any Req is high, arbitrate using the updated Last, latch operands, pulse Grant, and go to ISSUE (no IDLE bubble);
  - otherwise go to IDLE.
- Operand registers retain their last value outside ISSUE; Unit_* outputs are don't-care there.
- Result_ack while Result_valid = 0 has no effect.
- A requester must drop Req, or present a new operation, on the cycle after its Grant. A Req still high after Grant is treated as a new request.
- Op 11: Unit_In2 is still driven with B; the unit ignores it.

## Timing
- Reset values: Grant 0, Unit_In1 0, Unit_In2 0, Unit_Sel 00, Result 0, Result_id 0, Result_valid 0, Busy 0, Last NUM_REQ-1, state IDLE.
- Latency: request at edge k (state IDLE) → Grant high during cycle k+1 → Result_valid high from edge k+2.
- Throughput with Result_ack tied high and continuous requests: one result per 2 cycles.
- Reset mid-operation (ISSUE or DONE): the in-flight result is discarded and Result_valid is 0 after the reset edge. The round-robin pointer returns to NUM_REQ-1.
- Request and ack in the same cycle in DONE: the result is accepted and the next grant is issued at the same edge.
- Req changing during ISSUE/DONE: only the level sampled at the arbitrating edge matters.
- Pointer wrap: with Last = NUM_REQ-1, requester 0 is checked first.

## Test plan
- Single op: requester 2 Req with A=8'hA5, B=8'h0F, Op=00 from IDLE, Result_ack=1. Required response:
  - Grant = 4'b0100 for one cycle;
  - Unit_In1=8'hA5, Unit_In2=8'h0F, Unit_Sel=00 in ISSUE;
  - Result=8'hAA, Result_id=2, Result_valid for one cycle, 2 cycles after the request edge.
- All four Req held continuously, each with a distinct op (XOR, AND, OR, NOT on A=8'hF0, B=8'h3C), Result_ack=1. Required response:
  - Grants in order 0,1,2,3,0 every 2 cycles;
  - Results 8'hCC, 8'h30, 8'hFC, 8'h0F with matching Result_id.
- Back-pressure: hold Result_ack=0 for 5 cycles with Req pending. Required response:
  - Result_valid and Result stay stable and no Grant is issued;
  - the next Grant comes at the edge where Result_ack=1.
- Fairness wrap: after requester 3 is served, Req = 4'b1001. Required response: Grant goes to requester 0, then 3.
- Reset mid-op: Rst_n=0 during ISSUE. Required response:
  - the next cycle has all outputs at reset values with no Result_valid;
  - the next simultaneous Req = 4'b1111 is granted to requester 0 first.
- NUM_REQ=2 build: alternating Req from both requesters gives alternating Grant and a correct 1-bit Result_id.
